// File: rtl/uart_rx_buf_ctrl.sv
// Receive-side FWFT byte FIFO for the APB UART with overrun tracking,
// character-timeout detection and a registered combined interrupt.
module uart_rx_buf_ctrl #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AW       = 4,
  parameter int unsigned TO_TICKS = 640
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          s_tick,
  input  logic [7:0]    rx_data,
  input  logic          rx_done_tick,
  input  logic          rd_en,
  input  logic          flush,
  input  logic          clr_ovr,
  input  logic [1:0]    thr_sel,
  input  logic [2:0]    ien,
  output logic [7:0]    rd_data,
  output logic [AW:0]   level,
  output logic          empty,
  output logic          full,
  output logic          overrun,
  output logic          to_flag,
  output logic          irq
);

  localparam logic [1:0] TO_IDLE  = 2'd0;
  localparam logic [1:0] TO_COUNT = 2'd1;
  localparam logic [1:0] TO_FIRED = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   level_nxt;
  logic [AW:0]   thr;
  logic [1:0]    to_state;
  logic [9:0]    to_cnt;
  logic          push_ok, pop_ok, drop, thr_hit;

  assign empty   = (level == '0);
  assign full    = (level == (AW+1)'(DEPTH));
  assign pop_ok  = rd_en & ~empty;
  // A full FIFO still accepts a byte when a pop frees a slot in the same cycle.
  assign push_ok = rx_done_tick & (~full | rd_en);
  assign drop    = rx_done_tick & full & ~rd_en & ~flush;
  assign rd_data = empty ? 8'h00 : mem[rptr];
  assign to_flag = (to_state == TO_FIRED);

  always_comb begin
    thr = (AW+1)'(1);
    case (thr_sel)
      2'd0: thr = (AW+1)'(1);
      2'd1: thr = (AW+1)'(4);
      2'd2: thr = (AW+1)'(8);
      2'd3: thr = (AW+1)'(14);
      default: thr = (AW+1)'(1);
    endcase
  end

  assign thr_hit = (level >= thr);

  always_comb begin
    level_nxt = level;
    if (flush)
      level_nxt = '0;
    else if (push_ok && !pop_ok)
      level_nxt = level + (AW+1)'(1);
    else if (pop_ok && !push_ok)
      level_nxt = level - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (push_ok && !flush)
      mem[wptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      level   <= '0;
      overrun <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (push_ok) wptr <= wptr + AW'(1);
        if (pop_ok)  rptr <= rptr + AW'(1);
      end
      level <= level_nxt;
      if (drop)
        overrun <= 1'b1;
      else if (clr_ovr)
        overrun <= 1'b0;
      irq <= (ien[0] & thr_hit) | (ien[1] & to_flag) | (ien[2] & overrun);
    end
  end

  // Idle tracking keys off the post-edge occupancy so a draining pop lands in TO_IDLE directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_state <= TO_IDLE;
      to_cnt   <= '0;
    end else if (flush || level_nxt == '0) begin
      to_state <= TO_IDLE;
      to_cnt   <= '0;
    end else begin
      case (to_state)
        TO_IDLE: begin
          to_state <= TO_COUNT;
          to_cnt   <= '0;
        end
        TO_COUNT: begin
          if (push_ok || pop_ok)
            to_cnt <= '0;
          else if (s_tick) begin
            if (to_cnt == 10'(TO_TICKS - 1)) begin
              to_state <= TO_FIRED;
              to_cnt   <= '0;
            end else begin
              to_cnt <= to_cnt + 10'd1;
            end
          end
        end
        TO_FIRED: begin
          if (push_ok || pop_ok) begin
            to_state <= TO_COUNT;
            to_cnt   <= '0;
          end
        end
        default: begin
          to_state <= TO_IDLE;
          to_cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_buf_ctrl.sv
// Directed bench for uart_rx_buf_ctrl: a vector table for FIFO data/flag
// behaviour plus hand-written sequences for boundary, irq and timeout cases.
module tb_uart_rx_buf_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       s_tick, rx_done_tick, rd_en, flush, clr_ovr;
  logic [7:0] rx_data;
  logic [1:0] thr_sel;
  logic [2:0] ien;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic       empty, full, overrun, to_flag, irq;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       rx;
    logic [7:0] d;
    logic       rd;
    logic       fl;
    logic       co;
    int         lvl;
    logic       emp;
    logic       ful;
    logic       ovr;
    logic [7:0] rdd;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  uart_rx_buf_ctrl #(.DEPTH(16), .AW(4), .TO_TICKS(640)) dut (
    .clk(clk), .rst_n(rst_n), .s_tick(s_tick), .rx_data(rx_data),
    .rx_done_tick(rx_done_tick), .rd_en(rd_en), .flush(flush),
    .clr_ovr(clr_ovr), .thr_sel(thr_sel), .ien(ien), .rd_data(rd_data),
    .level(level), .empty(empty), .full(full), .overrun(overrun),
    .to_flag(to_flag), .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, sample 1 ns after the edge, then drop strobes.
  task automatic step(input logic rx, input logic [7:0] d, input logic rd,
                      input logic fl, input logic co, input logic tk);
    rx_done_tick = rx; rx_data = d; rd_en = rd; flush = fl; clr_ovr = co; s_tick = tk;
    @(posedge clk);
    #1;
    rx_done_tick = 1'b0; rd_en = 1'b0; flush = 1'b0; clr_ovr = 1'b0; s_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  function automatic void add(input logic rx, input logic [7:0] d, input logic rd,
                              input logic fl, input logic co, input int lvl,
                              input logic emp, input logic ful, input logic ovr,
                              input logic [7:0] rdd);
    vec_t v;
    v.rx = rx; v.d = d; v.rd = rd; v.fl = fl; v.co = co;
    v.lvl = lvl; v.emp = emp; v.ful = ful; v.ovr = ovr; v.rdd = rdd;
    vecs.push_back(v);
  endfunction

  initial begin
    rst_n = 1'b0; s_tick = 1'b0; rx_done_tick = 1'b0; rd_en = 1'b0;
    flush = 1'b0; clr_ovr = 1'b0; rx_data = 8'h00; thr_sel = 2'd0; ien = 3'b000;

    // Single byte, empty-pop ignore, push+pop into empty
    add(1, 8'hA5, 0, 0, 0, 1, 0, 0, 0, 8'hA5);
    add(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    add(1, 8'h11, 1, 0, 0, 1, 0, 0, 0, 8'h11);
    add(0, 8'h00, 1, 0, 0, 0, 1, 0, 0, 8'h00);
    // Fill 0x00..0x0F, drop 0x10, drain in order, clear overrun
    for (int i = 0; i < 16; i++)
      add(1, 8'(i), 0, 0, 0, i + 1, 0, (i == 15), 0, 8'h00);
    add(1, 8'h10, 0, 0, 0, 16, 0, 1, 1, 8'h00);
    for (int i = 0; i < 16; i++)
      add(0, 8'h00, 1, 0, 0, 15 - i, (i == 15), 0, 1, (i < 15) ? 8'(i + 1) : 8'h00);
    add(0, 8'h00, 0, 0, 1, 0, 1, 0, 0, 8'h00);

    #17;
    check("reset.level", 32'(level), 0);
    check("reset.empty", 32'(empty), 1);
    check("reset.full", 32'(full), 0);
    check("reset.overrun", 32'(overrun), 0);
    check("reset.to_flag", 32'(to_flag), 0);
    check("reset.irq", 32'(irq), 0);
    check("reset.rd_data", 32'(rd_data), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      step(vecs[i].rx, vecs[i].d, vecs[i].rd, vecs[i].fl, vecs[i].co, 1'b0);
      check($sformatf("vec%0d.level", i), 32'(level), 32'(vecs[i].lvl));
      check($sformatf("vec%0d.empty", i), 32'(empty), 32'(vecs[i].emp));
      check($sformatf("vec%0d.full", i), 32'(full), 32'(vecs[i].ful));
      check($sformatf("vec%0d.overrun", i), 32'(overrun), 32'(vecs[i].ovr));
      check($sformatf("vec%0d.rd_data", i), 32'(rd_data), 32'(vecs[i].rdd));
    end

    // Full boundary: simultaneous push/pop at DEPTH, then set-beats-clear on overrun
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("fb.full", 32'(full), 1);
    check("fb.head0", 32'(rd_data), 32'h20);
    step(1'b1, 8'h30, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fb.level", 32'(level), 16);
    check("fb.overrun", 32'(overrun), 0);
    check("fb.head1", 32'(rd_data), 32'h21);
    step(1'b1, 8'h31, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fb.set_wins", 32'(overrun), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    check("fb.clr", 32'(overrun), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fb.flush_level", 32'(level), 0);

    // Threshold irq (thr_sel=1 -> 4 entries), one-cycle lag
    thr_sel = 2'd1; ien = 3'b001;
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("thr.irq_lag", 32'(irq), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("thr.irq_set", 32'(irq), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("thr.irq_hold", 32'(irq), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("thr.irq_clr", 32'(irq), 0);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    thr_sel = 2'd0; ien = 3'b010;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);

    // Timeout: 639 ticks quiet, 640th fires, pop to empty clears
    step(1'b1, 8'h61, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(639);
    check("to.639_flag", 32'(to_flag), 0);
    check("to.639_irq", 32'(irq), 0);
    ticks(1);
    check("to.640_flag", 32'(to_flag), 1);
    check("to.640_irq_lag", 32'(irq), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to.irq", 32'(irq), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to.pop_flag", 32'(to_flag), 0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("to.pop_irq", 32'(irq), 0);

    // A push mid-count restarts the count; pop from FIRED with data left rearms
    step(1'b1, 8'h62, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(600);
    step(1'b1, 8'h63, 1'b0, 1'b0, 1'b0, 1'b0);
    ticks(639);
    check("to.restart_quiet", 32'(to_flag), 0);
    ticks(1);
    check("to.restart_fire", 32'(to_flag), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to.rearm_flag", 32'(to_flag), 0);
    check("to.rearm_head", 32'(rd_data), 32'h63);
    ticks(639);
    check("to.rearm_quiet", 32'(to_flag), 0);
    ticks(1);
    check("to.rearm_fire", 32'(to_flag), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("to.drain_empty", 32'(empty), 1);
    ien = 3'b000;

    // Flush with level=5, overrun=1, to_flag=1 and a same-cycle push
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'h70 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl.overrun_pre", 32'(overrun), 1);
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    check("fl.level_pre", 32'(level), 5);
    ticks(640);
    check("fl.to_flag_pre", 32'(to_flag), 1);
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 1'b0);
    check("fl.level", 32'(level), 0);
    check("fl.empty", 32'(empty), 1);
    check("fl.to_flag", 32'(to_flag), 0);
    check("fl.overrun", 32'(overrun), 1);
    check("fl.rd_data", 32'(rd_data), 0);
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0);
    check("fl.repush", 32'(rd_data), 32'h99);
    check("fl.repush_level", 32'(level), 1);

    // Asynchronous reset mid-operation
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst.level", 32'(level), 0);
    check("arst.empty", 32'(empty), 1);
    check("arst.overrun", 32'(overrun), 0);
    check("arst.rd_data", 32'(rd_data), 0);
    #3 rst_n = 1'b1;
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    check("arst.after", 32'(level), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_rx_buf_ctrl.md
# uart_rx_buf_ctrl

Receive-side buffer and interrupt scheduler for the APB UART. It sits between the UART receiver and the APB register file. It captures each received byte on the receiver's done tick into a first-word-fall-through FIFO, and serves pops from the APB RBR read path. It tracks overrun and a character-timeout, and raises a single registered interrupt from threshold, timeout and overrun sources.

## Interface
- `DEPTH`, default 16: FIFO entries; power of 2, ≥16.
- `AW`, default 4: log2(DEPTH).
- `TO_TICKS`, default 640: `s_tick` count for the timeout (4 character times at 16× oversampling, 10 bits per character); range 2..1023.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `s_tick` in 1: baud oversample tick, one `clk` wide.
- `rx_data` in 8: received byte, valid with `rx_done_tick`.
- `rx_done_tick` in 1: one-cycle strobe, byte complete.
- `rd_en` in 1: pop strobe (APB read of RBR).
- `flush` in 1: one-cycle FIFO clear.
- `clr_ovr` in 1: one-cycle overrun clear.
- `thr_sel` in 2: threshold select; 0→1, 1→4, 2→8, 3→14 entries.
- `ien` in 3: interrupt enables; [0] threshold, [1] timeout, [2] overrun.
- `rd_data` out 8: FIFO head; 8'h00 when empty.
- `level` out AW+1: current occupancy, 0..DEPTH.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `overrun` out 1: sticky, byte dropped.
- `to_flag` out 1: character timeout pending.
- `irq` out 1: registered combined interrupt.

## Operation
- **Storage:** circular buffer with AW-bit write and read pointers plus an AW+1-bit `level` counter. Pointers wrap DEPTH-1→0.
- **Push:** on `rx_done_tick` when `!full`, write `rx_data` at `wptr`, advance `wptr`, increment `level`.
- **Push when full:**
  - Byte is dropped and `overrun` sets.
  - Exception: `rd_en` in the same cycle. Then pop and push both occur, `level` stays DEPTH, and there is no overrun.
- **Pop:** on `rd_en` when `!empty`, advance `rptr` and decrement `level`. `rd_en` when empty is ignored and has no error.
- **Simultaneous push and pop, not empty:** `level` is unchanged and both pointers advance.
- **Push to empty with `rd_en` in the same cycle:** pop is ignored and the push is accepted.
- **`rd_data`:** combinational `mem[rptr]` when `!empty`, else 8'h00.
- **`flush`:** pointers, `level` and the timeout FSM return to reset values.
  - Flush has priority over push and pop in the same cycle; that byte is discarded.
  - Flush does not set or clear `overrun`.
- **`overrun`:** cleared by `clr_ovr`. A set in the same cycle as `clr_ovr` wins.
- **Timeout FSM:**
  - TO_IDLE: entered on `empty`. Counter is 0.
  - TO_IDLE → TO_COUNT: when the FIFO becomes non-empty.
  - TO_COUNT: each `s_tick` increments the counter. Any accepted push or pop resets the counter to 0 and the state stays TO_COUNT.
  - TO_COUNT → TO_FIRED: when the counter reaches TO_TICKS-1 and an `s_tick` arrives.
  - TO_FIRED: `to_flag` = 1.
  - TO_FIRED → TO_COUNT: on an accepted pop or push, with the counter cleared.
  - Any state → TO_IDLE: on `empty` or `flush`. `to_flag` = 0.
- **Threshold:** `thr_hit` = `level` ≥ selected threshold.
- **`irq`:** registered `(ien[0]&thr_hit) | (ien[1]&to_flag) | (ien[2]&overrun)`.

## Timing
- **Reset values:** `wptr`, `rptr`, `level` = 0; `empty` = 1; `full` = 0; `overrun` = 0; `to_flag` = 0; `irq` = 0; `rd_data` = 8'h00; FSM = TO_IDLE. Memory contents are undefined and never observable.
- **Push latency:** `level`, `empty` and `rd_data` update on the edge that samples `rx_done_tick`.
- **Pop latency:** new head is visible on `rd_data` the cycle after `rd_en`.
- **`overrun`:** sets on the edge sampling the dropped `rx_done_tick`.
- **`to_flag`:** asserts on the edge sampling the `s_tick` that completes TO_TICKS ticks with no intervening push or pop.
- **`irq`:** lags its sources by exactly one cycle.
- **Reset mid-operation:** all state clears asynchronously, with no partial push.

## Test plan
- **Single byte:** reset, push 8'hA5 → next cycle `rd_data`=8'hA5, `level`=1, `empty`=0. Pop → `empty`=1, `rd_data`=8'h00.
- **Fill, overrun and drain:**
  - Push 0x00..0x10 (17 bytes) → `full`=1 after the 16th push, `overrun`=1 after the 17th.
  - Pops return 0x00..0x0F in order.
  - `clr_ovr` → `overrun`=0.
- **Full boundary:** at `level`=16, assert `rd_en` and `rx_done_tick` in the same cycle → `level`=16, `overrun`=0, head advances.
- **Threshold IRQ:** `thr_sel`=1, `ien`=3'b001, push 4 bytes → `irq`=1 one cycle after the 4th push. One pop → `irq`=0 one cycle after the pop.
- **Timeout:** `TO_TICKS`=640, push 1 byte, then issue 639 `s_tick`s → `to_flag`=0. The 640th tick → `to_flag`=1 and, with `ien[1]`, `irq`=1 next cycle. A pop clears both.
- **Flush:** with `level`=5, `overrun`=1 and a same-cycle push, assert `flush` → `level`=0, `empty`=1, `to_flag`=0, `overrun` remains 1.
